// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// pong_pkg : shared state encoding and screen constants for the pong blocks
// Rev 1.0
// ============================================================================
package pong_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SERVE  = 3'd1;
  localparam state_t ST_PLAY   = 3'd2;
  localparam state_t ST_SCORED = 3'd3;
  localparam state_t ST_OVER   = 3'd4;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam int unsigned WIN_SCORE_DEFAULT = 9;

  // Renderer-side helpers treat every state except PLAY as "ball parked".
  function automatic logic state_holds_ball(input state_t s);
    return (s != ST_PLAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
// edge_rise : one-flop rising-edge detector for a clk-synchronous level input
// Rev 1.0
// ============================================================================
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_d;
  logic r_armed;

  // A level already high when reset releases is not a press: edges are only
  // reported once one post-reset sample of the input has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_d     <= i_d;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = i_d & ~r_d & r_armed;

endmodule
`default_nettype wire

// File: rtl/pong_referee.sv
`default_nettype none
// ============================================================================
// pong_referee : per-frame goal detection, scoring, serve delay and game end
// Rev 1.0
// ============================================================================
module pong_referee
  import pong_pkg::*;
#(
  parameter int unsigned LEFT_GOAL_X  = 2,
  parameter int unsigned RIGHT_GOAL_X = H_ACTIVE - 2,
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEFAULT,
  parameter int unsigned SERVE_DELAY  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic       point,
  output logic       game_over,
  output logic       winner
);

  localparam logic [9:0] c_LEFT_X     = 10'(LEFT_GOAL_X);
  localparam logic [9:0] c_RIGHT_X    = 10'(RIGHT_GOAL_X);
  localparam logic [3:0] c_WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] c_SERVE_LAST = 8'(SERVE_DELAY - 1);

  state_t     r_state;
  logic [7:0] r_serve_cnt;
  logic [3:0] r_p1;
  logic [3:0] r_p2;
  logic       r_point;
  logic       r_over;
  logic       r_winner;
  logic       r_dir;

  logic w_start_rise;
  logic w_left_goal;
  logic w_right_goal;
  logic w_p1_wins;
  logic w_p2_wins;

  edge_rise u_start_edge (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (start),
    .o_rise (w_start_rise)
  );

  assign w_left_goal  = (ball_x < c_LEFT_X);
  assign w_right_goal = (ball_x > c_RIGHT_X);
  assign w_p1_wins    = (r_p1 == c_WIN);
  assign w_p2_wins    = (r_p2 == c_WIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_serve_cnt <= 8'd0;
      r_p1        <= 4'd0;
      r_p2        <= 4'd0;
      r_point     <= 1'b0;
      r_over      <= 1'b0;
      r_winner    <= 1'b0;
      r_dir       <= 1'b0;
    end else begin
      r_point <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= 8'd0;
            r_dir       <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (r_serve_cnt == c_SERVE_LAST) begin
              r_state <= ST_PLAY;
            end else begin
              r_serve_cnt <= r_serve_cnt + 8'd1;
            end
          end
        end
        ST_PLAY: begin
          // Left edge wins a tie by ordering; the two windows cannot overlap.
          if (frame_tick) begin
            if (w_left_goal) begin
              r_p2    <= r_p2 + 4'd1;
              r_dir   <= 1'b0;
              r_point <= 1'b1;
              r_state <= ST_SCORED;
            end else if (w_right_goal) begin
              r_p1    <= r_p1 + 4'd1;
              r_dir   <= 1'b1;
              r_point <= 1'b1;
              r_state <= ST_SCORED;
            end
          end
        end
        ST_SCORED: begin
          if (w_p1_wins || w_p2_wins) begin
            r_state  <= ST_OVER;
            r_over   <= 1'b1;
            r_winner <= w_p2_wins;
          end else begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= 8'd0;
          end
        end
        ST_OVER: begin
          if (w_start_rise) begin
            r_p1        <= 4'd0;
            r_p2        <= 4'd0;
            r_over      <= 1'b0;
            r_winner    <= 1'b0;
            r_dir       <= 1'b1;
            r_serve_cnt <= 8'd0;
            r_state     <= ST_SERVE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign p1_score  = r_p1;
  assign p2_score  = r_p2;
  assign ball_hold = state_holds_ball(r_state);
  assign serve_dir = r_dir;
  assign point     = r_point;
  assign game_over = r_over;
  assign winner    = r_winner;

endmodule
`default_nettype wire

// File: doc/pong_referee.md
# pong_referee

Game-state controller sitting between the ball motion stage and the VGA renderer. Each frame it samples the ball x-coordinate, detects goals at the left and right screen edges, and keeps both players' scores. It holds the ball at centre during serve delays and freezes play when a player reaches the winning score. Its score and hold outputs feed the ball controller and the score overlay/renderer.

## Interface
- `LEFT_GOAL_X`, default 2: a goal for player 2 occurs when `ball_x < LEFT_GOAL_X`.
- `RIGHT_GOAL_X`, default 638: a goal for player 1 occurs when `ball_x > RIGHT_GOAL_X`.
- `WIN_SCORE`, default 9: score that ends the game, range 1..15.
- `SERVE_DELAY`, default 120: frame ticks the ball is held before release, range 1..255.

Ports:
- `clk` in 1: pixel clock (25.175 MHz domain).
- `reset` in 1: **asynchronous, active-low** reset.
- `frame_tick` in 1: one-cycle pulse, once per frame, at the start of vertical blanking.
- `start` in 1: level button, synchronous to `clk`; rising edges are detected internally.
- `ball_x` in 10: ball centre x, stable during blanking.
- `p1_score` out 4: player 1 score.
- `p2_score` out 4: player 2 score.
- `ball_hold` out 1: 1 means the ball controller must hold the ball at screen centre.
- `serve_dir` out 1: direction of the next serve (1 = rightward toward P2, 0 = leftward toward P1).
- `point` out 1: one-cycle pulse when a goal is registered.
- `game_over` out 1: the match is finished.
- `winner` out 1: valid while `game_over` is 1 (0 = P1, 1 = P2).

## Operation
- States: IDLE, SERVE, PLAY, SCORED, OVER.
- **Reset** (asynchronous, `reset`=0):
  - State goes to IDLE.
  - Scores, serve counter, `start_d`, `point`, `game_over`, `winner` and `serve_dir` all go to 0.
  - `ball_hold` = 1.
- Start edge: `start_rise = start & ~start_d`, where `start_d` is `start` registered every cycle.
- **IDLE:** `ball_hold`=1. On `start_rise` → SERVE; serve counter cleared; `serve_dir` = 1.
- **SERVE:** `ball_hold`=1.
  - Each `frame_tick` increments the serve counter.
  - On the tick where the counter equals `SERVE_DELAY-1` → PLAY.
  - `start` is ignored.
- **PLAY:** `ball_hold`=0. Goals are checked only on `frame_tick`:
  - If `ball_x < LEFT_GOAL_X`: `p2_score` += 1, `serve_dir` ← 0, `point` = 1 for one cycle, → SCORED.
  - Else if `ball_x > RIGHT_GOAL_X`: `p1_score` += 1, `serve_dir` ← 1, `point` = 1 for one cycle, → SCORED.
  - The two conditions are disjoint; the left check has priority by construction.
  - `start` is ignored.
- **SCORED** (one cycle): `ball_hold`=1.
  - If either score equals `WIN_SCORE` → OVER; `game_over` ← 1; `winner` ← (`p2_score == WIN_SCORE`).
  - Otherwise → SERVE with the serve counter cleared.
- **OVER:** `ball_hold`=1. Scores are frozen.
  - On `start_rise`: both scores ← 0, `game_over` ← 0, `winner` ← 0, `serve_dir` ← 1, counter cleared, → SERVE.
- Width and arithmetic rules:
  - Scores are 4-bit and never exceed `WIN_SCORE`; no wrap is possible.
  - The serve counter is 8-bit.
- `ball_x` is sampled only on a `frame_tick` cycle. Values outside PLAY, or between ticks, have no effect.

## Timing
- All outputs are registered.
- `ball_hold` is decoded from the registered state, so it is valid the cycle after the transition edge.
- `start_rise` is seen one cycle after `start` rises. The state changes at the edge following that cycle, so `ball_hold` falls or rises at most 2 cycles after input edges.
- Goal to score latency: the score, `point` and the SCORED state all update at the `frame_tick` edge. `game_over` updates one cycle later.
- Serve length: exactly `SERVE_DELAY` frame ticks, counted from the first tick after entering SERVE. PLAY begins at the edge of the `SERVE_DELAY`-th tick.
- A `frame_tick` arriving in the same cycle as the SERVE→PLAY transition is not checked for goals.
- Mid-operation reset: state and outputs take their reset values immediately, independent of `clk`. Operation resumes in IDLE on the first edge after `reset` deasserts.

## Structure
- Shared package (`pong_pkg`):
  - State enum and encoding (IDLE=0, SERVE=1, PLAY=2, SCORED=3, OVER=4; 3 bits).
  - Screen constants: `H_ACTIVE`=640, `V_ACTIVE`=480.
  - Default `WIN_SCORE`.
- Sub-module `edge_rise`: a one-flop rising-edge detector for `start`, reused later for paddle buttons.
- Everything else lives in one module.

## Test plan
- **Reset then start:**
  - `reset`=0 → all outputs 0 except `ball_hold`=1.
  - Release reset, pulse `start` → state SERVE.
  - `ball_hold` stays 1 for exactly 120 frame ticks, then 0.
- **Right goal:**
  - In PLAY, `ball_x`=639 on a `frame_tick` → `p1_score`=1, one-cycle `point`, `serve_dir`=1.
  - `ball_hold`=1 the next cycle; a new 120-tick serve follows.
- **Left goal:**
  - In PLAY, `ball_x`=1 on a tick → `p2_score`=1, `serve_dir`=0.
  - `ball_x`=2 or 638 → no score.
- **Between-tick immunity:** `ball_x`=700 held while `frame_tick`=0, returned to 320 before the tick → scores unchanged.
- **Win:**
  - `WIN_SCORE`=3; three P2 goals → `game_over`=1, `winner`=1, `ball_hold`=1.
  - Further goal conditions leave scores at 0/3.
  - A `start` edge → scores 0/0, SERVE.
- **Reset mid-PLAY:**
  - With scores 2/1, assert `reset` asynchronously between clock edges → outputs go to reset values immediately.
  - Held `start`=1 across reset release produces no edge until `start` toggles low then high.
